// File: rtl/raw_data_rr_arbiter.sv
// raw_data_rr_arbiter
//
// Purpose:
//   Shares one downstream raw-data consumer among NUM_SRC raw-data FIFOs.
//   A non-empty source is picked round-robin. One word is popped from it and
//   from its index FIFO at the same time. The word is then registered and
//   offered on a valid/accepted handshake, tagged with its source number.
//
// Ports:
//   clk               - system clock, all state updates on the rising edge
//   reset             - asynchronous, active-high reset
//   src_fifo_empty    - per-source FIFO empty flags
//   src_fifo_data     - per-source FIFO read data, source i at [i*DATA_W +: DATA_W]
//   src_fifo_pop      - per-source data FIFO pop, one-hot or zero
//   src_index_pop     - per-source index FIFO pop, always equal to src_fifo_pop
//   raw_data_out      - registered data word
//   raw_data_src      - source number of raw_data_out
//   raw_data_valid    - raw_data_out / raw_data_src are valid
//   raw_data_accepted - consumer takes the word (only looked at while valid)
//
// Build option:
//   ARB_BURST_EN - when defined, an accepted source that still has data is
//                  granted again directly. This repeats up to BURST_LEN
//                  consecutive words before the round-robin pointer moves on.
//                  When undefined, every accept returns to IDLE.

module raw_data_rr_arbiter #(
  parameter int NUM_SRC   = 4,
  parameter int DATA_W    = 32,
  parameter int SRC_W     = 2,
  parameter int BURST_LEN = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_SRC-1:0]        src_fifo_empty,
  input  logic [NUM_SRC*DATA_W-1:0] src_fifo_data,
  output logic [NUM_SRC-1:0]        src_fifo_pop,
  output logic [NUM_SRC-1:0]        src_index_pop,
  output logic [DATA_W-1:0]         raw_data_out,
  output logic [SRC_W-1:0]          raw_data_src,
  output logic                      raw_data_valid,
  input  logic                      raw_data_accepted
);

  typedef enum logic [3:0] {
    IDLE    = 4'b0001,
    POP     = 4'b0010,
    CAPTURE = 4'b0100,
    READY   = 4'b1000
  } state_t;

  localparam logic [NUM_SRC-1:0] ONE_HOT_0 = {{(NUM_SRC-1){1'b0}}, 1'b1};

  state_t            state;
  logic [SRC_W-1:0]  grant;
  logic [SRC_W-1:0]  last_grant;
  logic [SRC_W-1:0]  winner;
  logic [SRC_W-1:0]  cand;
  logic              any_req;
  logic [DATA_W-1:0] data_arr [NUM_SRC];

`ifdef ARB_BURST_EN
  localparam int BCW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  logic [BCW-1:0] burst_cnt;
`endif

  // Unpack the flat data bus so the granted word can be selected by index.
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_unpack
    assign data_arr[i] = src_fifo_data[i*DATA_W +: DATA_W];
  end

  // The index FIFO always moves together with its data FIFO.
  assign src_index_pop = src_fifo_pop;

  // Round-robin search. It starts just after the last accepted source and
  // wraps modulo NUM_SRC. The first non-empty candidate wins.
  always_comb begin
    any_req = 1'b0;
    winner  = '0;
    cand    = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      cand = SRC_W'((int'(last_grant) + k) % NUM_SRC);
      if (!any_req && !src_fifo_empty[cand]) begin
        any_req = 1'b1;
        winner  = cand;
      end
    end
  end

  // Sequencer: IDLE -> POP -> CAPTURE -> READY. All outputs are registered.
  // The pop pulse is loaded on the transition into POP, so it is high for
  // exactly the POP cycle. The FIFO is non-showahead, so its data is not
  // sampled until CAPTURE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      grant          <= '0;
      last_grant     <= SRC_W'(NUM_SRC - 1);
      src_fifo_pop   <= '0;
      raw_data_valid <= 1'b0;
      raw_data_out   <= '0;
      raw_data_src   <= '0;
`ifdef ARB_BURST_EN
      burst_cnt      <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          src_fifo_pop   <= '0;
          raw_data_valid <= 1'b0;
          if (any_req) begin
            grant        <= winner;
            src_fifo_pop <= ONE_HOT_0 << winner;
            state        <= POP;
          end
        end

        POP: begin
          src_fifo_pop <= '0;
          state        <= CAPTURE;
        end

        CAPTURE: begin
          raw_data_out   <= data_arr[grant];
          raw_data_src   <= grant;
          raw_data_valid <= 1'b1;
          state          <= READY;
        end

        READY: begin
          if (raw_data_accepted) begin
            raw_data_valid <= 1'b0;
`ifdef ARB_BURST_EN
            // Stay on the same source while it has data and the burst is
            // not used up. last_grant is left alone so that the round-robin
            // order continues correctly once the burst ends.
            if (!src_fifo_empty[grant] && (int'(burst_cnt) < BURST_LEN - 1)) begin
              burst_cnt    <= burst_cnt + 1'b1;
              src_fifo_pop <= ONE_HOT_0 << grant;
              state        <= POP;
            end else begin
              last_grant <= grant;
              burst_cnt  <= '0;
              state      <= IDLE;
            end
`else
            last_grant <= grant;
            state      <= IDLE;
`endif
          end
        end

        // Any illegal encoding falls back to a quiet IDLE.
        default: begin
          state          <= IDLE;
          src_fifo_pop   <= '0;
          raw_data_valid <= 1'b0;
          raw_data_out   <= '0;
          raw_data_src   <= '0;
        end
      endcase
    end
  end

endmodule
